// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional bounds checking is enabled with the FETCH_BOUNDS_CHECK_EN macro.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_KILL = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] byte_pc);
    return {byte_pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory, redirect and decode-side signals of the fetch unit.
// The master modport is the fetch unit; slave is memory plus decode.
interface instruction_fetch_unit_if;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
  logic        InstrFault;

  modport master (
    output Address,
    input  Instruction,
    input  Redirect,
    input  RedirectPC,
    output InstrValid,
    input  InstrReady,
    output InstrOut,
    output InstrPC,
    output InstrFault
  );

  modport slave (
    input  Address,
    output Instruction,
    output Redirect,
    output RedirectPC,
    input  InstrValid,
    output InstrReady,
    input  InstrOut,
    input  InstrPC,
    input  InstrFault
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of fetch entries with flush; head is the oldest entry.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t        mem_r [DEPTH];
  logic [AW-1:0]       rd_ptr_r;
  logic [AW-1:0]       wr_ptr_r;
  logic [AW:0]         count_r;

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Pipeline front end: owns the PC, issues word fetches and queues {PC, instr} for decode.
// Define FETCH_BOUNDS_CHECK_EN to flag fetches beyond IMEM_DEPTH words and replace them with NOP.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          IMEM_DEPTH  = 256
) (
  input  logic                     Clk,
  input  logic                     Rst,
  instruction_fetch_unit_if.master bus
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]   fetch_pc_r;
  logic          inflight_r;
  logic [31:0]   inflight_pc_r;
  fetch_state_t  state_r;
  fetch_state_t  state_s;

  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  q_din_s;
  logic          valid_s;
  logic          pop_s;
  logic          push_s;
  logic          kill_s;
  logic          issue_s;
  logic [CW:0]   occupancy_s;
  logic [31:0]   cap_instr_s;
  logic          cap_fault_s;

  assign valid_s     = (q_count != '0);
  assign pop_s       = valid_s & bus.InstrReady & ~bus.Redirect;
  assign kill_s      = bus.Redirect | (state_r == S_KILL);
  assign push_s      = inflight_r & ~kill_s;
  // Entries already queued or in flight, less the one leaving this cycle.
  assign occupancy_s = {1'b0, q_count} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
  assign issue_s     = (state_r == S_RUN) & ~bus.Redirect & (occupancy_s < (CW+1)'(QUEUE_DEPTH));

`ifdef FETCH_BOUNDS_CHECK_EN
  logic inflight_fault_r;
  logic issue_fault_s;

  assign issue_fault_s = ({2'b00, fetch_pc_r[31:2]} >= 32'(IMEM_DEPTH));
  assign cap_fault_s   = inflight_fault_r;
  assign cap_instr_s   = inflight_fault_r ? NOP_INSTR : bus.Instruction;

  // Fault tag travels with the outstanding request.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      inflight_fault_r <= 1'b0;
    end else if (issue_s) begin
      inflight_fault_r <= issue_fault_s;
    end else begin
      inflight_fault_r <= inflight_fault_r;
    end
  end
`else
  logic unused_imem_s;

  assign unused_imem_s = (IMEM_DEPTH > 0);
  assign cap_fault_s   = 1'b0;
  assign cap_instr_s   = bus.Instruction;
`endif

  // Entry captured from the memory response.
  always_comb begin
    q_din_s       = '0;
    q_din_s.pc    = inflight_pc_r;
    q_din_s.instr = cap_instr_s;
    q_din_s.fault = cap_fault_s;
  end

  // Next state: a redirect with a response outstanding (or mid-kill) enters S_KILL.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_RUN: begin
        if (bus.Redirect && inflight_r) begin
          state_s = S_KILL;
        end else begin
          state_s = S_RUN;
        end
      end
      S_KILL: begin
        if (bus.Redirect) begin
          state_s = S_KILL;
        end else begin
          state_s = S_RUN;
        end
      end
      default: state_s = S_RUN;
    endcase
  end

  // PC, outstanding request and FSM state registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
      state_r       <= S_RUN;
    end else begin
      state_r    <= state_s;
      inflight_r <= issue_s;
      if (bus.Redirect) begin
        fetch_pc_r <= word_align(bus.RedirectPC);
      end else if (issue_s) begin
        fetch_pc_r    <= fetch_pc_r + 32'd4;
        inflight_pc_r <= fetch_pc_r;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (Clk),
    .rst   (Rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.Redirect),
    .din   (q_din_s),
    .count (q_count),
    .head  (q_head)
  );

  assign bus.Address    = {2'b00, fetch_pc_r[31:2]};
  assign bus.InstrValid = valid_s;
  assign bus.InstrOut   = valid_s ? q_head.instr : 32'h0000_0000;
  assign bus.InstrPC    = valid_s ? q_head.pc    : 32'h0000_0000;
  assign bus.InstrFault = valid_s ? q_head.fault : 1'b0;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front end of the CPU pipeline, directly upstream of InstructionMemory.
- Owns the program counter and drives InstructionMemory's word Address.
- Captures the returned Instruction one cycle later into a small prefetch queue.
- Hands {PC, instruction} to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush, including discard of the in-flight memory response.

Parameters:
RESET_PC, 32'h0000_0000, byte PC loaded on reset; bits [1:0] must be 0
QUEUE_DEPTH, 2, prefetch queue entries (min 2, power of two)
IMEM_DEPTH, 256, number of valid words in InstructionMemory (used only by the optional feature)

Ports:
Clk  in  1  clock; all state updates on posedge
Rst  in  1  reset, asynchronous, active-high
Address  out  32  word index to InstructionMemory, equal to FetchPC[31:2] zero-extended
Instruction  in  32  InstructionMemory read data, valid the cycle after Address is presented
Redirect  in  1  pulse: flush and restart at RedirectPC
RedirectPC  in  32  byte target; bits [1:0] ignored (forced 0)
InstrValid  out  1  queue head valid to decode
InstrReady  in  1  decode accepts head; pop = InstrValid & InstrReady
InstrOut  out  32  head instruction
InstrPC  out  32  head byte PC
InstrFault  out  1  head fetched out of bounds (0 unless FETCH_BOUNDS_CHECK_EN)

Behaviour:
- Clock and reset: one clock, Clk. Rst is asynchronous and active-high.
- Reset values:
  - FetchPC = RESET_PC, so Address = RESET_PC>>2.
  - Queue count = 0, inflight = 0, state = S_RUN.
  - InstrValid = 0. InstrOut, InstrPC and InstrFault = 0.
- Memory model: InstructionMemory samples Address at posedge and presents Instruction during the following cycle.
- Issue:
  - Condition: issue = (state==S_RUN) & !Redirect & (count + inflight - pop < QUEUE_DEPTH).
  - On issue: inflight <= 1, inflightPC <= FetchPC, FetchPC <= FetchPC + 4 (wraps mod 2^32).
  - When not issuing: FetchPC holds and Address holds.
- Capture: when inflight=1 and no kill, push {inflightPC, Instruction, fault} into the queue at posedge.
  - The issue rule guarantees the queue never overflows. An overflow is a bug; the bench asserts on it.
- Latency and throughput:
  - First issue occurs in the first cycle after Rst deasserts.
  - InstrValid rises 2 cycles after issue. There is no bypass.
  - Steady-state throughput is 1 instruction/cycle while InstrReady=1.
- Backpressure: with InstrReady=0, the queue fills to QUEUE_DEPTH, issue stops, and the head and its outputs hold stable.
- Redirect (posedge with Redirect=1):
  - Queue is flushed: count=0, InstrValid=0 next cycle.
  - FetchPC <= {RedirectPC[31:2],2'b00}.
  - If inflight=1, state <= S_KILL; otherwise state stays S_RUN.
  - Any pop that cycle is ignored.
- S_KILL: the response arriving this cycle is discarded. No issue occurs. Next state is S_RUN.
- Redirect-to-InstrValid latency: 3 cycles without kill, 4 with kill.
- Redirect in S_KILL: takes the new target, stays S_KILL for one more cycle.
- Priority: Rst > Redirect > pop/push/issue.
- Simultaneous pop and push: count unchanged; head advances.
- Rst mid-operation: all in-flight and queued data dropped immediately (asynchronous).

Optional Feature:
Macro: FETCH_BOUNDS_CHECK_EN.
- Defined:
  - At issue, if FetchPC[31:2] >= IMEM_DEPTH, the entry's fault bit is set.
  - On capture, the instruction is replaced with NOP (32'h0000_0000).
  - InstrFault = head fault bit.
- Undefined:
  - No compare logic.
  - The raw Instruction is passed through.
  - InstrFault is tied 0.

Decomposition:
- fetch_pkg holds:
  - constant NOP_INSTR = 32'h0000_0000
  - typedef enum {S_RUN, S_KILL} fetch_state_t
  - typedef struct packed {pc[31:0], instr[31:0], fault} fetch_entry_t
- Sub-module fetch_queue: a parameterised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - Asynchronous reset on Rst.

Test Plan:
- Reset/streaming: preload memory word 0 = 12345678, word 1 = 9ABCDEF0, word 2 = 2468ACEF, word 3 = 13579BDF; RESET_PC=0; InstrReady=1 → first InstrValid in 3rd cycle after Rst deassertion; then PC/instr pairs 0/12345678, 4/9ABCDEF0, 8/2468ACEF, C/13579BDF, one per cycle.
- Backpressure: InstrReady=0 for 5 cycles after first valid → InstrPC stays 0 and Address stops at word 2 (queue holds 2 entries); on release → PCs 0,4,8,... with no gap or duplicate.
- Redirect with kill: Redirect=1, RedirectPC=32'h0000_0013 while inflight → next valid is PC 0x10 with memory word 4 (11112222) after 4 cycles; the killed word is never output.
- Redirect with simultaneous pop, and back-to-back Redirects (targets 0x8 then 0x18) → only the PC 0x18 stream is output.
- FETCH_BOUNDS_CHECK_EN, IMEM_DEPTH=8, redirect to 0x1C → PC 0x1C with InstrFault=0, then PC 0x20 with InstrOut=00000000 and InstrFault=1; without the macro, InstrFault=0 throughout.
- Asynchronous Rst asserted mid-stream between edges → InstrValid and Address (RESET_PC>>2) update immediately without a clock edge; the stream restarts at RESET_PC.
